// File: rtl/lm75a_temp_display.sv
// lm75a_temp_display: LM75A temperature word to sign/magnitude BCD, shown on a multiplexed 4-digit 7-segment display.
module lm75a_temp_display #(
   parameter int CLK_DIV    = 50000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        temp_valid,
   input  logic [15:0] temp_raw,
   output logic        busy,
   output logic        upd_done,
   output logic [15:0] disp_code,
   output logic [3:0]  dig,
   output logic [7:0]  seg
);
   localparam int DIV_W = $clog2(CLK_DIV);
   typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;
   state_t state, state_nx;
   logic [10:0] raw_q, pend_raw, mag;
   logic        pend, neg, start, unused_bits;
   logic [2:0]  frac, cnt;
   logic [19:0] dd;
   logic [11:0] bcd_adj;
   logic [6:0]  f10;
   logic [3:0]  tenths, hun, ten, uni, d3, d2, code, oh;
   logic [DIV_W-1:0] div;
   logic [1:0]  idx;
   logic [6:0]  glyph;
   logic [7:0]  seg_hi;
   assign unused_bits = ^temp_raw[4:0];
   assign start = (state == IDLE) && (temp_valid || pend);
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? ABS : IDLE;
         ABS:     state_nx = SHIFT;
         SHIFT:   state_nx = (cnt == 3'd7) ? DONE : SHIFT;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      busy = (state != IDLE);
   end
   // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
   always_comb begin
      bcd_adj = dd[19:8];
      for (int i = 0; i < 3; i++)
         bcd_adj[i*4 +: 4] = (dd[8+i*4 +: 4] >= 4'd5) ? dd[8+i*4 +: 4] + 4'd3 : dd[8+i*4 +: 4];
   end
   assign mag    = raw_q[10] ? -raw_q : raw_q;
   assign f10    = 7'({frac, 3'b000}) + 7'({frac, 1'b0});
   assign tenths = f10[6:3];
   assign hun    = dd[19:16];
   assign ten    = dd[15:12];
   assign uni    = dd[11:8];
   assign d3     = neg ? 4'hB : (hun != 4'd0 ? 4'h1 : 4'hA);
   assign d2     = (hun != 4'd0 || ten != 4'd0) ? ten : 4'hA;
   always_ff @(posedge clk) begin
      if (reset) begin
         pend      <= 1'b0;
         pend_raw  <= '0;
         raw_q     <= '0;
         neg       <= 1'b0;
         frac      <= '0;
         dd        <= '0;
         cnt       <= '0;
         upd_done  <= 1'b0;
         disp_code <= 16'hBBBB;
      end else begin
         upd_done <= (state == DONE);
         if (start) begin
            raw_q <= temp_valid ? temp_raw[15:5] : pend_raw;
            pend  <= 1'b0;
         end else if (temp_valid) begin
            pend     <= 1'b1;
            pend_raw <= temp_raw[15:5];
         end
         if (state == ABS) begin
            neg  <= raw_q[10];
            frac <= mag[2:0];
            dd   <= {12'd0, mag[10:3]};
            cnt  <= '0;
         end
         if (state == SHIFT) begin
            dd  <= {bcd_adj[10:0], dd[7:0], 1'b0};
            cnt <= cnt + 3'd1;
         end
         if (state == DONE) disp_code <= {d3, d2, uni, tenths};
      end
   end
   assign code = disp_code[idx*4 +: 4];
   always_comb begin
      case (code)
         4'h0:    glyph = 7'h3F;
         4'h1:    glyph = 7'h06;
         4'h2:    glyph = 7'h5B;
         4'h3:    glyph = 7'h4F;
         4'h4:    glyph = 7'h66;
         4'h5:    glyph = 7'h6D;
         4'h6:    glyph = 7'h7D;
         4'h7:    glyph = 7'h07;
         4'h8:    glyph = 7'h7F;
         4'h9:    glyph = 7'h6F;
         4'hB:    glyph = 7'h40;
         default: glyph = 7'h00;
      endcase
   end
   assign seg_hi = {idx == 2'd1, glyph};
   assign oh     = 4'b0001 << idx;
   // dig and seg load together on the slot boundary so no digit ever shows another's glyph.
   always_ff @(posedge clk) begin
      if (reset) begin
         div <= '0;
         idx <= '0;
         dig <= ACTIVE_LOW ? 4'hF : 4'h0;
         seg <= ACTIVE_LOW ? 8'hFF : 8'h00;
      end else if (div == DIV_W'(CLK_DIV - 1)) begin
         div <= '0;
         idx <= idx + 2'd1;
         dig <= ACTIVE_LOW ? ~oh : oh;
         seg <= ACTIVE_LOW ? ~seg_hi : seg_hi;
      end else begin
         div <= div + DIV_W'(1);
      end
   end
endmodule

// File: tb/tb_lm75a_temp_display.sv
// tb_lm75a_temp_display: vector table, random readings against an arithmetic model, and mux/pending/reset sequences.
module tb_lm75a_temp_display;
   logic        clk = 1'b0;
   logic        reset, temp_valid, busy, upd_done;
   logic [15:0] temp_raw, disp_code;
   logic [3:0]  dig;
   logic [7:0]  seg;
   int checks = 0, errors = 0;
   typedef struct {logic [15:0] raw; logic [15:0] exp;} vec_t;
   vec_t vecs[6];
   always #5 clk = ~clk;
   lm75a_temp_display #(.CLK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset(reset), .temp_valid(temp_valid), .temp_raw(temp_raw),
      .busy(busy), .upd_done(upd_done), .disp_code(disp_code), .dig(dig), .seg(seg)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [15:0] model(input logic [15:0] raw);
      int t, a, ip, tn, h, te, u;
      logic [10:0] v;
      logic [3:0] d3, d2;
      v  = raw[15:5];
      t  = v[10] ? int'(v) - 2048 : int'(v);
      a  = t < 0 ? -t : t;
      ip = a / 8;
      tn = (a % 8) * 10 / 8;
      h  = ip / 100;
      te = (ip / 10) % 10;
      u  = ip % 10;
      d3 = t < 0 ? 4'hB : (h != 0 ? 4'h1 : 4'hA);
      d2 = (h != 0 || te != 0) ? 4'(te) : 4'hA;
      return {d3, d2, 4'(u), 4'(tn)};
   endfunction
   task automatic convert(input logic [15:0] raw, output int lat);
      temp_raw = raw;
      temp_valid = 1'b1;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         temp_valid = 1'b0;
         if (upd_done) begin
            lat = k;
            break;
         end
      end
   endtask
   initial begin
      int lat, pulses, n;
      logic [15:0] r;
      logic [3:0] exp_dig[4];
      logic [7:0] exp_seg[4];
      vecs[0] = '{16'h1900, 16'hA250};
      vecs[1] = '{16'hE700, 16'hB250};
      vecs[2] = '{16'h7D00, 16'h1250};
      vecs[3] = '{16'hFFE0, 16'hBA01};
      vecs[4] = '{16'h0060, 16'hAA03};
      vecs[5] = '{16'h0000, 16'hAA00};
      exp_dig = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{8'hC0, 8'h12, 8'hA4, 8'hFF};
      reset = 1'b1;
      temp_valid = 1'b0;
      temp_raw = '0;
      repeat (4) @(negedge clk);
      chk("rst_disp", disp_code, 16'hBBBB);
      chk("rst_busy", busy, 0);
      chk("rst_upd", upd_done, 0);
      chk("rst_dig", dig, 4'hF);
      chk("rst_seg", seg, 8'hFF);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("slot0_dig_pre", dig, 4'hF);
      @(negedge clk);
      chk("slot1_dig", dig, 4'b1110);
      chk("slot1_seg", seg, 8'hBF);
      temp_raw = 16'h1900;
      temp_valid = 1'b1;
      @(negedge clk);
      temp_valid = 1'b0;
      chk("busy_after_strobe", busy, 1);
      for (int k = 2; k <= 11; k++) begin
         @(negedge clk);
         if (k < 11) chk("no_early_upd", upd_done, 0);
      end
      chk("upd_at_11", upd_done, 1);
      chk("disp_25", disp_code, 16'hA250);
      @(negedge clk);
      chk("upd_one_cycle", upd_done, 0);
      chk("idle_busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         convert(vecs[i].raw, lat);
         chk($sformatf("vec%0d_lat", i), lat, 11);
         chk($sformatf("vec%0d_code", i), disp_code, vecs[i].exp);
      end
      for (int i = 0; i < 24; i++) begin
         r = 16'($urandom);
         convert(r, lat);
         chk($sformatf("rand%0d_lat(%h)", i, r), lat, 11);
         chk($sformatf("rand%0d_code(%h)", i, r), disp_code, model(r));
      end
      pulses = 0;
      for (int k = 0; k < 46; k++) begin
         temp_valid = (k == 0 || k == 2 || k == 4);
         temp_raw = (k == 0) ? 16'h0100 : (k == 2) ? 16'h0200 : 16'h0300;
         @(negedge clk);
         if (upd_done) pulses++;
      end
      temp_valid = 1'b0;
      chk("pend_pulses", pulses, 2);
      chk("pend_code", disp_code, 16'hAA30);
      temp_raw = 16'h1900;
      temp_valid = 1'b1;
      @(negedge clk);
      temp_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_disp", disp_code, 16'hBBBB);
      chk("abort_upd", upd_done, 0);
      reset = 1'b0;
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (upd_done) pulses++;
      end
      chk("abort_no_upd", pulses, 0);
      chk("abort_disp_hold", disp_code, 16'hBBBB);
      convert(16'h1900, lat);
      chk("mux_code", disp_code, 16'hA250);
      n = 0;
      while (dig != 4'b0111 && n < 20) begin
         @(negedge clk);
         n++;
      end
      while (dig == 4'b0111 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("mux_align", n < 40, 1);
      for (int s = 0; s < 4; s++)
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("mux_dig_s%0d_c%0d", s, c), dig, exp_dig[s]);
            chk($sformatf("mux_seg_s%0d_c%0d", s, c), seg, exp_seg[s]);
            @(negedge clk);
         end
      chk("mux_wrap_dig", dig, 4'b1110);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
